// File: rtl/vector_stream_packer.sv
// vector_stream_packer
// Gathers scalar elements arriving on a valid/ready stream into one packed
// vector of VECTOR_LENGTH lanes and offers it on a valid/ready output.
// A packet that ends early (in_last) is closed at once, and its unused upper
// lanes are filled with PAD_VALUE, so the consumer always gets a full-width
// vector. While a vector is held, a new element can only be taken in the same
// cycle that the held vector is consumed. That element goes to lane 0.
module vector_stream_packer #(
  parameter int                       ELEMENT_WIDTH = 4,
  parameter int                       VECTOR_LENGTH = 5,
  parameter logic [ELEMENT_WIDTH-1:0] PAD_VALUE     = '0,
  parameter int                       COUNT_WIDTH   = 3
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [ELEMENT_WIDTH-1:0]               in_data,
  input  logic                                   in_valid,
  input  logic                                   in_last,
  output logic                                   in_ready,
  output logic [ELEMENT_WIDTH*VECTOR_LENGTH-1:0] out_vector,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_partial,
  output logic [COUNT_WIDTH-1:0]                 out_count
);

  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(VECTOR_LENGTH - 1);

  typedef enum logic {
    FILL,
    FULL
  } state_t;

  state_t                                     state_q, state_d;
  logic [COUNT_WIDTH-1:0]                     index_q, index_d;
  logic [COUNT_WIDTH-1:0]                     count_q, count_d;
  logic                                       partial_q, partial_d;
  logic [VECTOR_LENGTH-1:0][ELEMENT_WIDTH-1:0] lanes_q, lanes_d;

  logic in_acc;
  logic out_acc;
  logic closing;

  // Input is open whenever no vector is held, or the held one leaves this cycle.
  assign in_ready = (state_q == FILL) || out_ready;
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = (state_q == FULL) && out_ready;
  // The accepted element completes a vector when it fills the top lane or ends the packet.
  assign closing  = in_acc && ((index_q == LAST_IDX) || in_last);

  assign out_valid   = (state_q == FULL);
  assign out_vector  = lanes_q;
  assign out_count   = count_q;
  assign out_partial = partial_q;

  // State register: FULL while a completed vector waits for the consumer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a closing element always leads to FULL, even if it arrives in the same cycle that the held vector leaves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (closing) state_d = FULL;
      end
      FULL: begin
        if (out_acc) state_d = closing ? FULL : FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Lane writes, padding, and closing metadata for the next cycle.
  always_comb begin
    lanes_d   = lanes_q;
    index_d   = index_q;
    count_d   = count_q;
    partial_d = partial_q;
    if (in_acc) begin
      for (int k = 0; k < VECTOR_LENGTH; k++) begin
        if (COUNT_WIDTH'(k) == index_q) begin
          lanes_d[k] = in_data;
        end else if (closing && (COUNT_WIDTH'(k) > index_q)) begin
          lanes_d[k] = PAD_VALUE;
        end
      end
      if (closing) begin
        index_d   = '0;
        count_d   = index_q + COUNT_WIDTH'(1);
        partial_d = (index_q != LAST_IDX);
      end else begin
        index_d   = index_q + COUNT_WIDTH'(1);
      end
    end
  end

  // Datapath registers. A reset throws away any vector that is partly filled or held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lanes_q   <= '0;
      index_q   <= '0;
      count_q   <= '0;
      partial_q <= 1'b0;
    end else begin
      lanes_q   <= lanes_d;
      index_q   <= index_d;
      count_q   <= count_d;
      partial_q <= partial_d;
    end
  end

endmodule
